// File: rtl/xvga_timing_gen.sv
// Raster timing generator for the 1024x768@60 Hz XGA display path.
// Produces registered pixel/line counters plus sync, blank and frame markers.
module xvga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_STOP    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_STOP    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_count_q, frame_count_d;

  // Decode uses the next counter values so every registered output agrees.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_count_d = frame_count_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d     = 11'd0;
        line_start_d = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d      = 10'd0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
    blank_d = (hcount_d >= H_VIS_END) || (vcount_d >= V_VIS_END);
    hsync_d = ((hcount_d >= HS_START) && (hcount_d < HS_STOP)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((vcount_d >= VS_START) && (vcount_d < VS_STOP)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule
